// File: rtl/trap_pkg.sv
// trap_pkg: shared types, CSR addresses and mstatus update helpers for the trap sequencer
//   state_e      : sequencer states
//   CSR_*        : machine-mode CSR addresses touched by trap/return sequences
//   mstatus_trap : mstatus[12:0] after taking a trap
//   mstatus_mret : mstatus[12:0] after executing mret
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_STATUS,
        T_VEC,
        M_STATUS,
        M_EPC
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_HI = 12;
    localparam int MPP_LO = 11;

    function automatic logic [12:0] mstatus_trap(input logic [12:0] x);
        logic [12:0] y;
        y = x;
        y[MPIE] = x[MIE];
        y[MIE] = 1'b0;
        y[MPP_HI:MPP_LO] = 2'b11;
        return y;
    endfunction

    function automatic logic [12:0] mstatus_mret(input logic [12:0] x);
        logic [12:0] y;
        y = x;
        y[MIE] = x[MPIE];
        y[MPIE] = 1'b1;
        y[MPP_HI:MPP_LO] = 2'b11;
        return y;
    endfunction

endpackage

// File: rtl/trap_seq.sv
// trap_seq: multi-cycle trap/mret sequencer owning the machine CSR file's single write port
//   clk, rst                              : clock, synchronous active-high reset
//   exc_valid/exc_cause/exc_pc/exc_ack    : exception request, held until exc_ack pulse
//   mret_valid/mret_ack                   : mret request, held until mret_ack pulse
//   csri_valid/csri_addr/csri_wdata/ready : CSR-instruction writes, passed through only in IDLE
//   csr_wen/csr_addr/csr_wdata/csr_rdata  : CSR file port (combinational read of csr_addr)
//   redirect_valid/redirect_pc            : fetch redirect pulse and target
//   busy                                  : sequence in progress
module trap_seq
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [DATA_WIDTH-1:0] exc_cause,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    output logic                  exc_ack,
    input  logic                  mret_valid,
    output logic                  mret_ack,
    input  logic                  csri_valid,
    input  logic [11:0]           csri_addr,
    input  logic [DATA_WIDTH-1:0] csri_wdata,
    output logic                  csri_ready,
    output logic                  csr_wen,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs are forced low while rst is asserted so an aborted sequence
    // never leaks a write, ack or redirect in the reset cycle itself.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        pc_d           = pc_q;
        exc_ack        = 1'b0;
        mret_ack       = 1'b0;
        csri_ready     = 1'b0;
        csr_wen        = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = 1'b0;
        if (!rst) begin
            busy = state_q != IDLE;
            case (state_q)
                IDLE: begin
                    if (exc_valid) begin
                        state_d = T_EPC;
                        cause_d = exc_cause;
                        pc_d    = exc_pc;
                    end else if (mret_valid) begin
                        state_d = M_STATUS;
                    end else if (csri_valid) begin
                        csri_ready = 1'b1;
                        csr_wen    = 1'b1;
                        csr_addr   = csri_addr;
                        csr_wdata  = csri_wdata;
                    end
                end
                T_EPC: begin
                    csr_wen   = 1'b1;
                    csr_addr  = CSR_MEPC;
                    csr_wdata = pc_q;
                    state_d   = T_CAUSE;
                end
                T_CAUSE: begin
                    csr_wen   = 1'b1;
                    csr_addr  = CSR_MCAUSE;
                    csr_wdata = cause_q;
                    state_d   = T_STATUS;
                end
                T_STATUS: begin
                    csr_wen   = 1'b1;
                    csr_addr  = CSR_MSTATUS;
                    csr_wdata = {csr_rdata[DATA_WIDTH-1:13], mstatus_trap(csr_rdata[12:0])};
                    state_d   = T_VEC;
                end
                T_VEC: begin
                    // Only direct mode is supported, so the mode bits are simply dropped.
                    csr_addr       = CSR_MTVEC;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
                    exc_ack        = 1'b1;
                    state_d        = IDLE;
                end
                M_STATUS: begin
                    csr_wen   = 1'b1;
                    csr_addr  = CSR_MSTATUS;
                    csr_wdata = {csr_rdata[DATA_WIDTH-1:13], mstatus_mret(csr_rdata[12:0])};
                    state_d   = M_EPC;
                end
                M_EPC: begin
                    csr_addr       = CSR_MEPC;
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_rdata;
                    mret_ack       = 1'b1;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: scoreboard bench for trap_seq with a small CSR file model
module tb_trap_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_ack;
    logic        mret_valid = 1'b0;
    logic        mret_ack;
    logic        csri_valid = 1'b0;
    logic [11:0] csri_addr = '0;
    logic [31:0] csri_wdata = '0;
    logic        csri_ready;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    trap_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_ack(exc_ack),
        .mret_valid(mret_valid), .mret_ack(mret_ack),
        .csri_valid(csri_valid), .csri_addr(csri_addr), .csri_wdata(csri_wdata),
        .csri_ready(csri_ready),
        .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] m_status = 32'h0000_0008;
    logic [31:0] m_tvec   = 32'h8000_0100;
    logic [31:0] m_epc    = 32'h0;
    logic [31:0] m_cause  = 32'h0;

    assign csr_rdata = csr_addr == 12'h300 ? m_status :
                       csr_addr == 12'h305 ? m_tvec   :
                       csr_addr == 12'h341 ? m_epc    :
                       csr_addr == 12'h342 ? m_cause  : 32'h0;

    always @(posedge clk) begin
        if (csr_wen) begin
            case (csr_addr)
                12'h300: m_status <= csr_wdata;
                12'h305: m_tvec   <= csr_wdata;
                12'h341: m_epc    <= csr_wdata;
                12'h342: m_cause  <= csr_wdata;
                default: ;
            endcase
        end
    end

    typedef struct packed {
        int          cyc;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic [31:0] rpc;
        logic        ea;
        logic        ma;
        logic        rdy;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_got, mon_exp;
    int  n_chk = 0;
    int  n_pass = 0;

    function automatic ev_t mk(int c, logic w, logic [11:0] a, logic [31:0] d, logic rv,
                               logic [31:0] rp, logic ea, logic ma, logic rd);
        ev_t e;
        e.cyc = c; e.wen = w; e.addr = a; e.wdata = d; e.rv = rv;
        e.rpc = rp; e.ea = ea; e.ma = ma; e.rdy = rd;
        return e;
    endfunction

    function automatic string fmt(ev_t e);
        return $sformatf("cyc=%0d wen=%b addr=%h wdata=%h redir=%b rpc=%h eack=%b mack=%b rdy=%b",
                         e.cyc, e.wen, e.addr, e.wdata, e.rv, e.rpc, e.ea, e.ma, e.rdy);
    endfunction

    task automatic chk(input bit ok, input string name, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (csri_ready) chk(!busy, "ready_while_busy", $sformatf("busy=%b required 0", busy));
            if (csr_wen | redirect_valid | exc_ack | mret_ack | csri_ready) begin
                mon_got = mk(cyc, csr_wen, csr_addr, csr_wdata, redirect_valid, redirect_pc,
                             exc_ack, mret_ack, csri_ready);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", $sformatf("got %s, required none", fmt(mon_got)));
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk(mon_got == mon_exp, "event",
                        $sformatf("got %s, required %s", fmt(mon_got), fmt(mon_exp)));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_mret, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = is_mret ? mret_ack : exc_ack;
        end
        chk(seen, name, $sformatf("ack seen=%b required 1 within 20 cycles", seen));
    endtask

    task automatic push_exc(input int c, input logic [31:0] cause, input logic [31:0] pc,
                            input logic [31:0] st, input logic [31:0] vec);
        exp_q.push_back(mk(c + 1, 1'b1, 12'h341, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(c + 2, 1'b1, 12'h342, cause, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(c + 3, 1'b1, 12'h300, st, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(c + 4, 1'b0, 12'h305, 32'h0, 1'b1, vec, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic push_mret(input int c, input logic [31:0] st, input logic [31:0] epc);
        exp_q.push_back(mk(c + 1, 1'b1, 12'h300, st, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(c + 2, 1'b0, 12'h341, 32'h0, 1'b1, epc, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic exc_seq(input logic [31:0] cause, input logic [31:0] pc,
                           input logic [31:0] st, input logic [31:0] vec);
        tick();
        exc_valid = 1'b1; exc_cause = cause; exc_pc = pc;
        push_exc(cyc, cause, pc, st, vec);
        wait_ack(1'b0, "exc_ack");
        tick();
        exc_valid = 1'b0;
    endtask

    task automatic mret_seq(input logic [31:0] st, input logic [31:0] epc);
        tick();
        mret_valid = 1'b1;
        push_mret(cyc, st, epc);
        wait_ack(1'b1, "mret_ack");
        tick();
        mret_valid = 1'b0;
    endtask

    task automatic csri_wr(input logic [11:0] a, input logic [31:0] d);
        tick();
        csri_valid = 1'b1; csri_addr = a; csri_wdata = d;
        exp_q.push_back(mk(cyc, 1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
        tick();
        csri_valid = 1'b0;
    endtask

    function automatic bit outs_zero();
        return !(exc_ack | mret_ack | csri_ready | csr_wen | redirect_valid | busy)
               && csr_addr == 12'h0 && csr_wdata == 32'h0 && redirect_pc == 32'h0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int c;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(outs_zero(), "reset_idle",
            $sformatf("wen=%b addr=%h busy=%b redir=%b required all 0", csr_wen, csr_addr, busy, redirect_valid));

        exc_seq(32'd11, 32'h8000_0040, 32'h0000_1880, 32'h8000_0100);

        csri_wr(12'h341, 32'h8000_0044);
        mret_seq(32'h0000_1888, 32'h8000_0044);

        csri_wr(12'h305, 32'h8000_0200);

        // exc, mret and csri together: exception, then mret, then csri
        tick();
        exc_valid = 1'b1; mret_valid = 1'b1; csri_valid = 1'b1;
        exc_cause = 32'd2; exc_pc = 32'h8000_0080;
        csri_addr = 12'h342; csri_wdata = 32'h0000_0055;
        c = cyc;
        push_exc(c, 32'd2, 32'h8000_0080, 32'h0000_1880, 32'h8000_0200);
        push_mret(c + 5, 32'h0000_1888, 32'h8000_0080);
        exp_q.push_back(mk(c + 8, 1'b1, 12'h342, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
        tick();
        exc_cause = 32'd99; exc_pc = 32'hDEAD_BEEF;
        wait_ack(1'b0, "arb_exc_ack");
        tick();
        exc_valid = 1'b0;
        wait_ack(1'b1, "arb_mret_ack");
        tick();
        mret_valid = 1'b0;
        @(negedge clk);
        tick();
        csri_valid = 1'b0;

        csri_wr(12'h305, 32'h8000_0103);
        exc_seq(32'd7, 32'h8000_0010, 32'h0000_1880, 32'h8000_0100);

        // reset while in T_CAUSE aborts the sequence
        tick();
        exc_valid = 1'b1; exc_cause = 32'd5; exc_pc = 32'h8000_0020;
        exp_q.push_back(mk(cyc + 1, 1'b1, 12'h341, 32'h8000_0020, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; exc_valid = 1'b0;
        @(negedge clk);
        chk(outs_zero(), "reset_abort_idle",
            $sformatf("wen=%b addr=%h busy=%b redir=%b ack=%b required all 0",
                      csr_wen, csr_addr, busy, redirect_valid, exc_ack));
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (exc_ack | mret_ack | redirect_valid) n++;
        end
        chk(n == 0, "no_ack_after_reset", $sformatf("ack/redirect cycles=%0d required 0", n));

        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "queue_drained", $sformatf("pending=%0d required 0", exp_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
